// File: rtl/stitch_pkg.sv
// Shared types, defaults and typedef macros for the stitch interconnect endpoints.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// The struct typedefs depend on per-instance widths, so they are generated by
// macros invoked inside each module after its own width typedefs exist.

`ifndef STITCH_PKG_SV
`define STITCH_PKG_SV

// TCDM request/response as seen by the router.
`define STITCH_TYPEDEF_TCDM_REQ_T(req_t, addr_t, data_t, strb_t) \
  typedef struct packed {                                          \
    logic  valid;                                                  \
    addr_t addr;                                                   \
    logic  write;                                                  \
    data_t data;                                                   \
    strb_t strb;                                                   \
  } req_t;

`define STITCH_TYPEDEF_TCDM_RSP_T(rsp_t, data_t) \
  typedef struct packed {                        \
    logic  valid;                                \
    data_t data;                                 \
  } rsp_t;

// Per-bank request payload (handshake carried separately).
`define STITCH_TYPEDEF_BANK_Q_T(q_t, addr_t, data_t, strb_t) \
  typedef struct packed {                                      \
    addr_t addr;                                               \
    logic  write;                                              \
    data_t data;                                               \
    strb_t strb;                                               \
  } q_t;

// Per-bank response payload.
`define STITCH_TYPEDEF_BANK_P_T(p_t, data_t) \
  typedef struct packed {                    \
    data_t data;                             \
  } p_t;

`endif

package stitch_pkg;

  localparam int unsigned StitchDefaultBankLatency  = 1;
  localparam int unsigned StitchDefaultRspFifoDepth = 3;

  // Number of byte enables for a given data width.
  function automatic int unsigned stitch_strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/stitch_rsp_fifo.sv
// Synchronous-reset FIFO with registered storage and no fall-through.
// Latency: a push in cycle t is visible on data_o/empty_o in cycle t+1.
// Backpressure: full_o when Depth entries held; push while full only legal with a pop.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write side
//   pop_i, data_o     read side; data_o is the head entry, 0 while empty
//   full_o, empty_o   occupancy flags

module stitch_rsp_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

  if (Depth < 1) begin : g_bad_depth
    $error("stitch_rsp_fifo: Depth must be at least 1");
  end

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                push_en;
  logic                pop_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);

  // A pop frees the slot the push needs, so push on a full FIFO is fine then.
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o && !pop_en))
        else $error("stitch_rsp_fifo: push while full");
    end
  end

endmodule

// File: rtl/stitch_bank_adapter.sv
// Per-bank endpoint: TCDM request/response stream to a fixed-latency single-port SRAM.
// Latency: request accepted in cycle t gives p_valid_o in cycle t+BankLatency+1.
// Backpressure: credit counter caps outstanding requests at RspFifoDepth; q_ready_o
//               depends on the counter only, so a stalled response side never drops data.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   q_valid_i/q_ready_o, q_addr_i,
//   q_write_i, q_data_i, q_strb_i        request channel from the router
//   p_valid_o/p_ready_i, p_data_o        response channel (read data, 0 for writes)
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_be_o, mem_rdata_i   SRAM pins

module stitch_bank_adapter
  import stitch_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 10,
  parameter int unsigned BankLatency  = StitchDefaultBankLatency,
  parameter int unsigned RspFifoDepth = StitchDefaultRspFifoDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   q_valid_i,
  output logic                   q_ready_o,
  input  logic [AddrWidth-1:0]   q_addr_i,
  input  logic                   q_write_i,
  input  logic [DataWidth-1:0]   q_data_i,
  input  logic [DataWidth/8-1:0] q_strb_i,
  output logic                   p_valid_o,
  input  logic                   p_ready_i,
  output logic [DataWidth-1:0]   p_data_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned StrbWidth = stitch_strb_width(DataWidth);
  localparam int unsigned CntWidth  = $clog2(RspFifoDepth + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(RspFifoDepth);

  if (DataWidth == 0 || (DataWidth % 8) != 0) begin : g_bad_data_width
    $error("stitch_bank_adapter: DataWidth must be a non-zero multiple of 8");
  end
  if (BankLatency < 1) begin : g_bad_latency
    $error("stitch_bank_adapter: BankLatency must be at least 1");
  end
  if (RspFifoDepth < 1) begin : g_bad_depth
    $error("stitch_bank_adapter: RspFifoDepth must be at least 1");
  end

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  `STITCH_TYPEDEF_BANK_Q_T(bank_q_t, addr_t, data_t, strb_t)
  `STITCH_TYPEDEF_BANK_P_T(bank_p_t, data_t)

  bank_q_t q_req;
  bank_p_t rsp_in;
  bank_p_t rsp_out;

  logic                q_acc;
  logic                p_acc;
  logic [CntWidth-1:0] cnt_q;

  logic [BankLatency-1:0] pipe_vld_q;
  logic [BankLatency-1:0] pipe_wr_q;

  logic rsp_push;
  logic rsp_full;
  logic rsp_empty;

  // ---------------------------------------------------------------------------
  // Request side: accept straight into the SRAM in the same cycle.
  // ---------------------------------------------------------------------------
  assign q_req = '{addr: q_addr_i, write: q_write_i, data: q_data_i, strb: q_strb_i};

  // Every outstanding request owns a FIFO slot, hence the FIFO cannot overflow.
  assign q_ready_o = !rst_i && (cnt_q < CntMax);
  assign q_acc     = q_valid_i & q_ready_o;

  assign mem_req_o   = q_acc;
  assign mem_we_o    = q_req.write;
  assign mem_addr_o  = q_req.addr;
  assign mem_wdata_o = q_req.data;
  assign mem_be_o    = q_req.strb;

  // Outstanding = accepted but response not yet handshaken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({q_acc, p_acc})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking pipeline: mirrors the SRAM latency so the last stage lines up with
  // mem_rdata_i. It never stalls; the credit guarantees room at the FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      pipe_wr_q  <= '0;
    end else begin
      pipe_vld_q[0] <= q_acc;
      pipe_wr_q[0]  <= q_req.write;
      for (int i = 1; i < int'(BankLatency); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_wr_q[i]  <= pipe_wr_q[i-1];
      end
    end
  end

  assign rsp_push = pipe_vld_q[BankLatency-1];

  // Writes return a zero data word so the router sees one response per request.
  always_comb begin
    rsp_in = '0;
    if (!pipe_wr_q[BankLatency-1]) begin
      rsp_in.data = mem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response buffer
  // ---------------------------------------------------------------------------
  stitch_rsp_fifo #(
    .Width ($bits(bank_p_t)),
    .Depth (RspFifoDepth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_push),
    .data_i  (rsp_in),
    .pop_i   (p_acc),
    .data_o  (rsp_out),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  // Suppressed while reset is held so flushed entries are never offered.
  assign p_valid_o = !rst_i && !rsp_empty;
  assign p_acc     = p_valid_o & p_ready_i;
  assign p_data_o  = p_valid_o ? rsp_out.data : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(rsp_push && rsp_full && !p_acc))
        else $error("stitch_bank_adapter: response FIFO overflow");
      assert (cnt_q <= CntMax)
        else $error("stitch_bank_adapter: outstanding counter out of range");
    end
  end

endmodule
